// File: rtl/calc_result_bcd_if.sv
// Handshake/data bundle between the calculator, the BCD formatter and its consumer.
interface calc_result_bcd_if;
  logic        calc_done;
  logic [15:0] calc_result;
  logic        calc_error;
  logic        calc_overflow;
  logic        signed_mode;
  logic        out_ack;
  logic [19:0] bcd;
  logic        neg;
  logic        err;
  logic        ovf;
  logic        out_valid;
  logic        busy;
  logic        missed;

  // Upstream calculator plus downstream consumer side
  modport master (
    output calc_done, calc_result, calc_error, calc_overflow, signed_mode, out_ack,
    input  bcd, neg, err, ovf, out_valid, busy, missed
  );

  // Formatter side
  modport slave (
    input  calc_done, calc_result, calc_error, calc_overflow, signed_mode, out_ack,
    output bcd, neg, err, ovf, out_valid, busy, missed
  );
endinterface

// File: rtl/calc_result_bcd.sv
// Captures a calculator result on the rising edge of done, converts it to five
// BCD digits plus sign with 16 double-dabble steps, and holds it until acked.
module calc_result_bcd (
  input  logic                clk,
  input  logic                rst,
  calc_result_bcd_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t      state_q;
  logic        done_q;
  logic [3:0]  cnt_q;
  logic [35:0] sr_q;
  logic [19:0] bcd_q;
  logic        neg_q, err_q, ovf_q, missed_q;

  logic        cap, take, neg_d;
  logic [15:0] mag_d;
  logic [35:0] adj, sh_d;

  assign cap   = bus.calc_done & ~done_q;
  // A capture is accepted in IDLE, or in HOLD when the consumer acks the same cycle
  assign take  = cap & ((state_q == IDLE) | ((state_q == HOLD) & bus.out_ack));
  assign neg_d = bus.signed_mode & bus.calc_result[15];
  // 0x8000 negates to itself, which read unsigned is the correct 32768
  assign mag_d = neg_d ? (16'd0 - bus.calc_result) : bus.calc_result;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 5; i++) begin
      if (adj[16 + 4*i +: 4] >= 4'd5)
        adj[16 + 4*i +: 4] = adj[16 + 4*i +: 4] + 4'd3;
    end
    sh_d = {adj[34:0], 1'b0};
  end

  // Control FSM with registered outputs and sticky missed-edge flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      cnt_q    <= 4'd0;
      sr_q     <= 36'd0;
      bcd_q    <= 20'd0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      done_q <= bus.calc_done;
      if (take) begin
        err_q <= bus.calc_error;
        ovf_q <= bus.calc_overflow;
        neg_q <= neg_d;
        cnt_q <= 4'd0;
        if (bus.calc_error) begin
          bcd_q   <= 20'd0;
          state_q <= HOLD;
        end else begin
          sr_q    <= {20'd0, mag_d};
          state_q <= CONV;
        end
      end else begin
        if (cap) missed_q <= 1'b1;
        case (state_q)
          CONV: begin
            sr_q  <= sh_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              bcd_q   <= sh_d[35:16];
              state_q <= HOLD;
            end
          end
          HOLD: if (bus.out_ack) state_q <= IDLE;
          default: ;
        endcase
      end
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.neg       = neg_q;
  assign bus.err       = err_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q == CONV);
  assign bus.missed    = missed_q;
endmodule

// File: tb/tb_calc_result_bcd.sv
// Directed bench for calc_result_bcd: conversion values, latency, error and
// overflow paths, collisions, held done level and mid-conversion reset.
module tb_calc_result_bcd;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  calc_result_bcd_if u_if ();

  calc_result_bcd u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise done for one cycle with the given operands; returns just after the capture edge
  task automatic start(input logic [15:0] res, input logic sm, input logic er, input logic ov);
    u_if.calc_result   = res;
    u_if.signed_mode   = sm;
    u_if.calc_error    = er;
    u_if.calc_overflow = ov;
    u_if.calc_done     = 1'b1;
    tick(1);
    u_if.calc_done     = 1'b0;
  endtask

  task automatic ack();
    u_if.out_ack = 1'b1;
    tick(1);
    u_if.out_ack = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bcd"}, 32'(u_if.bcd), 32'h0);
    chk({tag, "_flags"}, {25'd0, u_if.neg, u_if.err, u_if.ovf, u_if.out_valid,
                          u_if.busy, u_if.missed, 1'b0}, 32'h0);
  endtask

  initial begin
    u_if.calc_done = 0; u_if.calc_result = 0; u_if.calc_error = 0;
    u_if.calc_overflow = 0; u_if.signed_mode = 0; u_if.out_ack = 0;
    #12;
    chk_zero("reset");
    @(posedge clk); #1; rst = 1'b0;

    // Unsigned 12345 with latency and hold stability
    start(16'h3039, 1'b0, 1'b0, 1'b0);
    chk("u_busy_e0", 32'(u_if.busy), 1);
    chk("u_valid_e0", 32'(u_if.out_valid), 0);
    tick(15);
    chk("u_valid_e15", 32'(u_if.out_valid), 0);
    chk("u_busy_e15", 32'(u_if.busy), 1);
    tick(1);
    chk("u_valid_e16", 32'(u_if.out_valid), 1);
    chk("u_busy_e16", 32'(u_if.busy), 0);
    chk("u_bcd", 32'(u_if.bcd), 32'h12345);
    chk("u_flags", {29'd0, u_if.neg, u_if.err, u_if.ovf}, 0);
    tick(5);
    chk("u_hold_bcd", 32'(u_if.bcd), 32'h12345);
    chk("u_hold_valid", 32'(u_if.out_valid), 1);
    ack();
    chk("u_ack_valid", 32'(u_if.out_valid), 0);
    chk("u_ack_busy", 32'(u_if.busy), 0);

    // Signed and unsigned boundary values
    start(16'hFFFF, 1'b1, 1'b0, 1'b0); tick(16);
    chk("s_m1_bcd", 32'(u_if.bcd), 32'h00001);
    chk("s_m1_neg", 32'(u_if.neg), 1);
    ack();
    start(16'h8000, 1'b1, 1'b0, 1'b0); tick(16);
    chk("s_min_bcd", 32'(u_if.bcd), 32'h32768);
    chk("s_min_neg", 32'(u_if.neg), 1);
    ack();
    start(16'hFFFF, 1'b0, 1'b0, 1'b0); tick(16);
    chk("u_max_bcd", 32'(u_if.bcd), 32'h65535);
    chk("u_max_neg", 32'(u_if.neg), 0);
    ack();

    // Divide-by-zero: one-cycle path, digits cleared
    start(16'h0000, 1'b0, 1'b1, 1'b0);
    chk("e_valid", 32'(u_if.out_valid), 1);
    chk("e_busy", 32'(u_if.busy), 0);
    chk("e_err", 32'(u_if.err), 1);
    chk("e_bcd", 32'(u_if.bcd), 0);
    ack();

    // Overflow flag carried through a normal conversion
    start(16'h0000, 1'b0, 1'b0, 1'b1); tick(16);
    chk("o_valid", 32'(u_if.out_valid), 1);
    chk("o_ovf", 32'(u_if.ovf), 1);
    chk("o_err", 32'(u_if.err), 0);
    chk("o_bcd", 32'(u_if.bcd), 0);
    ack();
    chk("no_missed", 32'(u_if.missed), 0);

    // Second edge during CONV is dropped and flagged
    start(16'd1234, 1'b0, 1'b0, 1'b0);
    tick(7);
    u_if.calc_result = 16'h1111;
    u_if.calc_done = 1'b1;
    tick(1);
    u_if.calc_done = 1'b0;
    chk("c_missed", 32'(u_if.missed), 1);
    chk("c_busy", 32'(u_if.busy), 1);
    tick(8);
    chk("c_valid", 32'(u_if.out_valid), 1);
    chk("c_bcd", 32'(u_if.bcd), 32'h01234);

    // Ack plus new edge in HOLD starts a fresh conversion
    u_if.calc_result = 16'd99;
    u_if.out_ack = 1'b1;
    u_if.calc_done = 1'b1;
    tick(1);
    u_if.out_ack = 1'b0;
    u_if.calc_done = 1'b0;
    chk("h_valid_e0", 32'(u_if.out_valid), 0);
    chk("h_busy_e0", 32'(u_if.busy), 1);
    tick(15);
    chk("h_valid_e15", 32'(u_if.out_valid), 0);
    tick(1);
    chk("h_valid_e16", 32'(u_if.out_valid), 1);
    chk("h_bcd", 32'(u_if.bcd), 32'h00099);
    chk("h_missed", 32'(u_if.missed), 1);
    ack();

    // A done level held high captures only once
    u_if.calc_result = 16'd7;
    u_if.calc_done = 1'b1;
    tick(17);
    chk("l_bcd", 32'(u_if.bcd), 32'h00007);
    chk("l_valid", 32'(u_if.out_valid), 1);
    ack();
    tick(2);
    chk("l_idle", {30'd0, u_if.busy, u_if.out_valid}, 0);
    u_if.calc_done = 1'b0;
    tick(1);

    // Reset mid-conversion clears everything immediately
    start(16'h3039, 1'b0, 1'b0, 1'b0);
    tick(9);
    chk("r_busy", 32'(u_if.busy), 1);
    #2 rst = 1'b1;
    #1 chk_zero("r_async");
    tick(1);
    rst = 1'b0;
    start(16'd100, 1'b0, 1'b0, 1'b0);
    tick(16);
    chk("r_valid", 32'(u_if.out_valid), 1);
    chk("r_bcd", 32'(u_if.bcd), 32'h00100);
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
